// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the sequential MULTU/DIVU
//                unit: operation encoding, FSM states, ALU control codes and
//                the iteration count.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic {
    MULTU = 1'b0,
    DIVU  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam int N_ITER = 32;
  localparam int CNT_W  = 5;

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 32-bit combinational ALU shared by the multiply/divide
//                datapath (MIPS-style control encoding).
//  Ports       : ctrl - operation select (AND/OR/ADD/SUB/SLT/NOR)
//                a, b - 32-bit operands
//                y    - 32-bit result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
  import muldiv_pkg::*;
(
  input  logic [3:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative unsigned 32x32 multiplier (shift-add) and 32/32
//                divider (restoring), one bit per cycle, fixed latency.
//                All add/subtract work goes through a single shared ALU.
//  Ports       : clk, rst         - clock, async active-high reset
//                start, op        - launch request, 0 = MULTU / 1 = DIVU
//                op_a, op_b       - unsigned operands
//                abort            - cancel the operation in flight
//                busy, done       - unit occupied / result committed pulse
//                hi, lo           - architectural HI/LO result registers
//                div_by_zero      - DIVU divisor was zero (valid with done)
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  op_e              r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_w_hi;    // P_hi for MULTU, remainder R for DIVU
  logic [31:0]      r_w_lo;    // P_lo for MULTU, quotient Q for DIVU
  logic             r_dbz;

  logic [32:0]      w_shift;
  logic [3:0]       w_alu_ctrl;
  logic [31:0]      w_alu_a;
  logic [31:0]      w_alu_b;
  logic [31:0]      w_alu_y;
  logic [31:0]      w_sum;
  logic             w_carry;
  logic             w_ge;

  // Divider: partial remainder shifted left with the next dividend bit.
  assign w_shift = {r_w_hi, r_w_lo[31]};

  assign w_alu_ctrl = (r_state != RUN) ? ALU_AND :
                      (r_op == DIVU)   ? ALU_SUB : ALU_ADD;
  assign w_alu_a    = (r_op == DIVU) ? w_shift[31:0] : r_w_hi;
  assign w_alu_b    = (r_op == DIVU) ? r_b : r_a;

  alu u_alu (
    .ctrl (w_alu_ctrl),
    .a    (w_alu_a),
    .b    (w_alu_b),
    .y    (w_alu_y)
  );

  // Multiplier: add only when the current multiplier bit is set; an unsigned
  // wrap of the sum reveals the carry-out of the 32-bit add.
  assign w_sum   = r_w_lo[0] ? w_alu_y : r_w_hi;
  assign w_carry = r_w_lo[0] & (w_alu_y < r_a);

  // Divider: subtract succeeds when the 33-bit shifted value is >= divisor.
  assign w_ge = w_shift[32] | (w_shift[31:0] >= r_b);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= MULTU;
      r_a         <= '0;
      r_b         <= '0;
      r_w_hi      <= '0;
      r_w_lo      <= '0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_op  <= op_e'(op);
            r_a   <= op_a;
            r_b   <= op_b;
            r_cnt <= '0;
            busy  <= 1'b1;
            if (op_e'(op) == DIVU && op_b == 32'h0) begin
              // Divide by zero bypasses the iterations entirely.
              r_w_hi  <= op_a;
              r_w_lo  <= 32'hFFFF_FFFF;
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_w_hi  <= '0;
              r_w_lo  <= (op_e'(op) == DIVU) ? op_a : op_b;
              r_dbz   <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end else begin
            if (r_op == DIVU) begin
              r_w_hi <= w_ge ? w_alu_y : w_shift[31:0];
              r_w_lo <= {r_w_lo[30:0], w_ge};
            end else begin
              {r_w_hi, r_w_lo} <= {w_carry, w_sum, r_w_lo[31:1]};
            end
            // Counter saturates at the last iteration instead of wrapping.
            if (r_cnt == CNT_W'(N_ITER - 1)) begin
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          if (!abort) begin
            done        <= 1'b1;
            hi          <= r_w_hi;
            lo          <= r_w_lo;
            div_by_zero <= r_dbz;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Self-checking bench for muldiv_seq. A cycle-level behavioural
//                model (countdown + 64-bit arithmetic) predicts every output
//                each cycle; directed cases pin the model with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .op_a        (op_a),
    .op_b        (op_b),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt  = 0;      // cycles remaining until commit, 0 = idle
  logic [31:0] p_hi   = '0;
  logic [31:0] p_lo   = '0;
  logic        p_dbz  = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic        m_dbz  = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    int          c;
    logic        commit;
    logic [63:0] prod;
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_dbz  <= 1'b0;
    end else begin
      c      = m_cnt;
      commit = 1'b0;
      if (c > 0) begin
        if (abort) c = 0;
        else begin
          c = c - 1;
          if (c == 0) commit = 1'b1;
        end
      end else if (start && !abort) begin
        if (op) begin
          if (op_b == 0) begin
            p_hi <= op_a; p_lo <= 32'hFFFF_FFFF; p_dbz <= 1'b1; c = 1;
          end else begin
            p_hi <= op_a % op_b; p_lo <= op_a / op_b; p_dbz <= 1'b0; c = 33;
          end
        end else begin
          prod = 64'(op_a) * 64'(op_b);
          p_hi <= prod[63:32]; p_lo <= prod[31:0]; p_dbz <= 1'b0; c = 33;
        end
      end
      m_cnt  <= c;
      m_done <= commit;
      m_dbz  <= commit ? p_dbz : 1'b0;
      if (commit) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_cnt > 0));
    chk("done", 64'(done), 64'(m_done));
    chk("hi", 64'(hi), 64'(m_hi));
    chk("lo", 64'(lo), 64'(m_lo));
    chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
  end

  // Launch one operation and wait (bounded) for done.
  // lat = clock edges after the edge that sampled start.
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output logic rd, output int lat);
    @(negedge clk);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) chk("timeout_done", 64'(lat), 64'(0));
    rh = hi; rl = lo; rd = div_by_zero;
  endtask

  logic [31:0] rh, rl;
  logic        rd;
  int          lat;
  int          ndone;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;

    // MULTU max x max
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, rh, rl, rd, lat);
    chk("mul_max_hi", 64'(rh), 64'hFFFF_FFFE);
    chk("mul_max_lo", 64'(rl), 64'h0000_0001);
    chk("mul_max_lat", 64'(lat), 64'd33);
    chk("mul_max_dbz", 64'(rd), 64'(0));

    // DIVU 0x80000000 / 0x80000001
    do_op(1'b1, 32'h8000_0000, 32'h8000_0001, rh, rl, rd, lat);
    chk("div_big_lo", 64'(rl), 64'h0);
    chk("div_big_hi", 64'(rh), 64'h8000_0000);

    // DIVU by zero
    do_op(1'b1, 32'h1234, 32'h0, rh, rl, rd, lat);
    chk("dbz_lat", 64'(lat), 64'd1);
    chk("dbz_hi", 64'(rh), 64'h1234);
    chk("dbz_lo", 64'(rl), 64'hFFFF_FFFF);
    chk("dbz_flag", 64'(rd), 64'd1);

    // DIVU 100 / 7
    do_op(1'b1, 32'd100, 32'd7, rh, rl, rd, lat);
    chk("div_100_7_lo", 64'(rl), 64'd14);
    chk("div_100_7_hi", 64'(rh), 64'd2);
    chk("div_100_7_dbz", 64'(rd), 64'd0);
    chk("div_100_7_lat", 64'(lat), 64'd33);

    // Abort at RUN iteration 10
    @(negedge clk);
    start = 1'b1; op = 1'b0; op_a = 32'hFFFF; op_b = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd2);
    chk("abort_lo", 64'(lo), 64'd14);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_hi_kept", 64'(hi), 64'd2);

    // Abort together with start in IDLE: ignored
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 1'b0; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 64'(busy), 64'd0);

    // Second start while busy is ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; op_a = 32'd6; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 1'b1; op_a = 32'd9; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("busy_start_lo", 64'(lo), 64'd42);
        chk("busy_start_hi", 64'(hi), 64'd0);
      end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);

    // Reset mid-RUN, then normal operation
    @(negedge clk);
    start = 1'b1; op = 1'b0; op_a = 32'hDEAD; op_b = 32'hBEEF;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 32'd3, 32'd5, rh, rl, rd, lat);
    chk("post_rst_lo", 64'(rl), 64'd15);
    chk("post_rst_hi", 64'(rh), 64'd0);

    // Randomized traffic, checked by the per-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 79) == 0);
      case ($urandom_range(0, 3))
        0: begin op_a = $urandom; op_b = 32'h0; end
        1: begin op_a = $urandom_range(0, 255); op_b = $urandom_range(1, 15); end
        2: begin op_a = 32'hFFFF_FFFF; op_b = $urandom; end
        default: begin op_a = $urandom; op_b = $urandom; end
      endcase
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
